led_fade_seq: RTL and testbench
===============================

Name: led_fade_seq

Overview:
- Upstream intensity sequencer for the 4-bit first-order PWM LED driver stage.
- Accepts brightness commands over a valid/ready handshake.
- Produces a 4-bit intensity word that either steps immediately, fades linearly toward a target, or breathes continuously between 0 and a peak level.
- Its intensity output connects directly to the PWM stage's 4-bit intensity input.

Parameters:
- STEP_DIV, 65536: clk cycles per base tick; legal range 2..2^24.
- HOLD_TICKS, 8: steps spent at each breathe extreme (peak and zero); legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_mode  in  2  00=SET, 01=FADE, 10=BREATHE, 11=OFF.
- cmd_level  in  4  target level (SET/FADE) or peak level (BREATHE).
- cmd_rate  in  4  base ticks per intensity step, minus 1 (0 means one step per tick).
- intensity  out  4  registered level to the PWM stage.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a FADE reaches its target.

Behaviour:
- Reset values: intensity=0, cmd_ready=1, busy=0, done=0, state=IDLE, prescaler=0, rate counter=0.
- Prescaler:
  - Counts 0..STEP_DIV-1, then wraps.
  - tick is asserted for the single cycle when the count is STEP_DIV-1.
  - The prescaler runs freely and is never cleared by commands.
- Rate counter:
  - Counts ticks 0..rate_q and generates step on the tick where the count equals rate_q, then clears.
  - Clears on every command accept.
  - rate_q is latched from cmd_rate on accept.
- Handshake:
  - A command is accepted on a cycle where cmd_valid && cmd_ready.
  - cmd_ready=1 in IDLE and all BREATHE states; cmd_ready=0 in FADE.
  - cmd_ready is a function of registered state only, never of cmd_valid.
  - Command fields are sampled only on the accept cycle.
- States: IDLE, FADE, BR_UP, BR_HOLD_HI, BR_DOWN, BR_HOLD_LO.
- Accept SET:
  - intensity <= cmd_level on the accept edge; next state IDLE. Latency 1 cycle.
  - No done pulse.
- Accept OFF: intensity <= 0; next state IDLE.
- Accept FADE:
  - target_q <= cmd_level.
  - If cmd_level == intensity: stay IDLE and pulse done the next cycle.
  - Otherwise go to FADE.
- FADE state:
  - On each step, intensity moves by ±1 toward target_q.
  - On the step that makes intensity == target_q: go to IDLE, and done=1 in the cycle after that edge.
  - No overshoot; the count saturates at target.
- Accept BREATHE:
  - peak_q <= cmd_level; intensity is unchanged.
  - If peak_q == 0: intensity <= 0, go to IDLE.
  - Otherwise go to BR_UP.
- BR_UP: on each step, intensity+1. When the stepped value equals peak_q, go to BR_HOLD_HI with hold counter=0.
  - Entering BR_UP with intensity > peak_q: step down to peak_q, then go to BR_HOLD_HI.
- BR_HOLD_HI: hold counter increments on each step. After HOLD_TICKS steps, go to BR_DOWN.
- BR_DOWN: on each step, intensity-1. On reaching 0, go to BR_HOLD_LO.
- BR_HOLD_LO: after HOLD_TICKS steps, go to BR_UP.
- BREATHE repeats until a new command is accepted.
- A command accepted in any BREATHE state:
  - Takes effect on that edge, exactly as if it were accepted in IDLE.
  - The hold counter is cleared.
- Arithmetic:
  - intensity never wraps; it is bounded to 0..15 by the state logic.
  - Prescaler width is clog2(STEP_DIV).
- Simultaneous events: an accept and a step in the same cycle — the accept wins and the step is discarded.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); any in-flight command is lost.
- done is never asserted while rst_n=0.

Test Plan (STEP_DIV=4, HOLD_TICKS=2):
1. Reset, then SET level=9 -> cmd_ready=1 throughout; intensity=9 one cycle after accept; busy stays 0; done stays 0.
2. From 3, FADE level=7 rate=0 -> cmd_ready=0; intensity reaches 4,5,6,7 at 4-cycle intervals; a single-cycle done after 7; back in IDLE with cmd_ready=1.
3. From 10, FADE level=2 rate=1 -> intensity decrements once every 8 cycles down to 2 with no undershoot. Hold cmd_valid=1 during the fade -> no accept until IDLE.
4. From 0, BREATHE level=3 rate=0 -> 1,2,3; held for 2 steps; then 2,1,0; held for 2 steps; then repeats. Then OFF accepted mid-BR_DOWN -> intensity=0 next cycle, busy=0.
5. FADE level equal to the current intensity (5) -> no state change; done pulse on the cycle after accept.
6. Assert rst_n=0 asynchronously mid-FADE at intensity=6 -> intensity=0, busy=0, cmd_ready=1 immediately. Release, then FADE level=1 -> completes normally.

Source files
------------

// File: rtl/led_fade_seq_if.sv
// Command channel of the LED intensity sequencer.
//   cmd_valid  : master -> slave, command present
//   cmd_ready  : slave -> master, command can be taken this cycle
//   cmd_mode   : 00=SET, 01=FADE, 10=BREATHE, 11=OFF
//   cmd_level  : target level (SET/FADE) or peak level (BREATHE)
//   cmd_rate   : base ticks per intensity step, minus 1
interface led_fade_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_level;
    logic [3:0] cmd_rate;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_level,
        output cmd_rate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_level,
        input  cmd_rate,
        output cmd_ready
    );
endinterface

// File: rtl/led_fade_seq.sv
// LED intensity sequencer feeding the 4-bit PWM driver stage.
// Takes brightness commands over a valid/ready channel and produces a
// registered 4-bit intensity that steps at once (SET/OFF), ramps linearly
// toward a target (FADE) or breathes between 0 and a peak (BREATHE).
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd        : command channel (slave side)
//   intensity  : registered level to the PWM stage
//   busy       : high whenever the sequencer is not IDLE
//   done       : one-cycle pulse when a FADE lands on its target
module led_fade_seq #(
    parameter int unsigned STEP_DIV   = 65536,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_fade_seq_if.slave        cmd,
    output logic [3:0]           intensity,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned    PW        = $clog2(STEP_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD_TICKS - 1);

    localparam logic [1:0] MODE_SET     = 2'b00;
    localparam logic [1:0] MODE_FADE    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FADE,
        ST_BR_UP,
        ST_BR_HOLD_HI,
        ST_BR_DOWN,
        ST_BR_HOLD_LO
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    rcnt_q, rcnt_d;
    logic [3:0]    rate_q, rate_d;
    logic [3:0]    int_q, int_d;
    logic [3:0]    target_q, target_d;
    logic [3:0]    peak_q, peak_d;
    logic [7:0]    hold_q, hold_d;
    logic          done_q, done_d;

    logic          tick;
    logic          step;
    logic          accept;
    logic [3:0]    up_v;
    logic [3:0]    dn_v;

    // The prescaler free-runs; commands never re-phase it.
    assign tick   = (presc_q == PRESC_MAX);
    assign step   = tick && (rcnt_q == rate_q);
    assign accept = cmd.cmd_valid && cmd.cmd_ready;

    // Only used where the state logic guarantees no wrap.
    assign up_v = int_q + 4'd1;
    assign dn_v = int_q - 4'd1;

    assign cmd.cmd_ready = (state_q != ST_FADE);
    assign busy          = (state_q != ST_IDLE);
    assign intensity     = int_q;
    assign done          = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            rcnt_q   <= '0;
            rate_q   <= '0;
            int_q    <= '0;
            target_q <= '0;
            peak_q   <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rcnt_q   <= rcnt_d;
            rate_q   <= rate_d;
            int_q    <= int_d;
            target_q <= target_d;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;
        rcnt_d   = rcnt_q;
        rate_d   = rate_q;
        int_d    = int_q;
        target_d = target_q;
        peak_d   = peak_q;
        hold_d   = hold_q;
        done_d   = 1'b0;

        if (tick) begin
            rcnt_d = (rcnt_q == rate_q) ? 4'd0 : rcnt_q + 4'd1;
        end

        // An accept takes priority; a step landing on the same edge is dropped.
        if (accept) begin
            rcnt_d = '0;
            rate_d = cmd.cmd_rate;
            hold_d = '0;
            case (cmd.cmd_mode)
                MODE_SET: begin
                    int_d   = cmd.cmd_level;
                    state_d = ST_IDLE;
                end
                MODE_FADE: begin
                    target_d = cmd.cmd_level;
                    if (cmd.cmd_level == int_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FADE;
                    end
                end
                MODE_BREATHE: begin
                    peak_d = cmd.cmd_level;
                    if (cmd.cmd_level == 4'd0) begin
                        int_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BR_UP;
                    end
                end
                default: begin
                    int_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (step) begin
            case (state_q)
                ST_FADE: begin
                    if (int_q < target_q) begin
                        int_d = up_v;
                        if (up_v == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        int_d = dn_v;
                        if (dn_v == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_BR_UP: begin
                    // Breathe may start above the peak; walk down to it first.
                    if (int_q < peak_q) begin
                        int_d = up_v;
                        if (up_v == peak_q) begin
                            state_d = ST_BR_HOLD_HI;
                            hold_d  = '0;
                        end
                    end else if (int_q > peak_q) begin
                        int_d = dn_v;
                        if (dn_v == peak_q) begin
                            state_d = ST_BR_HOLD_HI;
                            hold_d  = '0;
                        end
                    end else begin
                        state_d = ST_BR_HOLD_HI;
                        hold_d  = '0;
                    end
                end
                ST_BR_HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_BR_DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                ST_BR_DOWN: begin
                    if (int_q == 4'd0) begin
                        state_d = ST_BR_HOLD_LO;
                        hold_d  = '0;
                    end else begin
                        int_d = dn_v;
                        if (dn_v == 4'd0) begin
                            state_d = ST_BR_HOLD_LO;
                            hold_d  = '0;
                        end
                    end
                end
                ST_BR_HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_BR_UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fade_seq.sv
module tb_led_fade_seq;

    localparam logic [1:0] M_SET     = 2'b00;
    localparam logic [1:0] M_FADE    = 2'b01;
    localparam logic [1:0] M_BREATHE = 2'b10;
    localparam logic [1:0] M_OFF     = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [3:0] intensity;
    logic       busy;
    logic       done;

    led_fade_seq_if cmd_if ();

    led_fade_seq #(
        .STEP_DIV   (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if.slave),
        .intensity (intensity),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected intensity changes: level and cycles since the previous change
    // (gap 0 = timing not checked, prescaler phase is free-running).
    typedef struct {
        int lvl;
        int gap;
    } exp_t;

    exp_t       sbq[$];
    int         checks;
    int         errors;
    int         cycle;
    int         last_chg;
    logic [3:0] prev_int;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int lvl, input int gap);
        exp_t e;
        e.lvl = lvl;
        e.gap = gap;
        sbq.push_back(e);
    endtask

    // One clock: sample at the falling edge and score any intensity change.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cycle++;
        if (intensity !== prev_int) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_change", intensity, prev_int);
            end else begin
                e = sbq.pop_front();
                chk("sb_level", intensity, e.lvl);
                if (e.gap != 0) chk("sb_gap", cycle - last_chg, e.gap);
            end
            last_chg = cycle;
            prev_int = intensity;
        end
    endtask

    task automatic send(input logic [1:0] mode, input logic [3:0] lvl, input logic [3:0] rate);
        logic accepted;
        accepted = 1'b0;
        cmd_if.cmd_mode  = mode;
        cmd_if.cmd_level = lvl;
        cmd_if.cmd_rate  = rate;
        cmd_if.cmd_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            if (cmd_if.cmd_ready) accepted = 1'b1;
            cyc();
        end
        cmd_if.cmd_valid = 1'b0;
        chk("cmd_accepted", accepted, 1'b1);
    endtask

    task automatic wait_level(input logic [3:0] lvl, input int max_cyc);
        for (int n = 0; n < max_cyc && intensity !== lvl; n++) cyc();
        chk("reach_level", intensity, lvl);
    endtask

    task automatic drain(input int max_cyc);
        for (int n = 0; n < max_cyc && sbq.size() != 0; n++) cyc();
        chk("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cycle    = 0;
        last_chg = 0;
        prev_int = 4'd0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mode  = M_SET;
        cmd_if.cmd_level = 4'd0;
        cmd_if.cmd_rate  = 4'd0;
        rst_n = 1'b1;

        // 1: reset, then SET 9
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_intensity", intensity, 4'd0);
        chk("rst_ready", cmd_if.cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        prev_int = intensity;
        last_chg = cycle;
        push(9, 0);
        send(M_SET, 4'd9, 4'd0);
        chk("set_intensity", intensity, 4'd9);
        chk("set_ready", cmd_if.cmd_ready, 1'b1);
        chk("set_busy", busy, 1'b0);
        chk("set_done", done, 1'b0);

        // 2: from 3, FADE up to 7 at one step per tick
        push(3, 1);
        send(M_SET, 4'd3, 4'd0);
        push(4, 0); push(5, 4); push(6, 4); push(7, 4);
        send(M_FADE, 4'd7, 4'd0);
        chk("fade_up_ready", cmd_if.cmd_ready, 1'b0);
        chk("fade_up_busy", busy, 1'b1);
        wait_level(4'd7, 100);
        chk("fade_up_done_pulse", done, 1'b1);
        cyc();
        chk("fade_up_done_clear", done, 1'b0);
        chk("fade_up_idle_ready", cmd_if.cmd_ready, 1'b1);
        chk("fade_up_idle_busy", busy, 1'b0);

        // 3: from 10, FADE down to 2 at rate 1 while a SET 15 waits
        push(10, 0);
        send(M_SET, 4'd10, 4'd0);
        push(9, 0);
        for (int v = 8; v >= 2; v--) push(v, 8);
        push(15, 1);
        send(M_FADE, 4'd2, 4'd1);
        cmd_if.cmd_mode  = M_SET;
        cmd_if.cmd_level = 4'd15;
        cmd_if.cmd_rate  = 4'd0;
        cmd_if.cmd_valid = 1'b1;
        wait_level(4'd2, 200);
        chk("fade_dn_done_pulse", done, 1'b1);
        chk("fade_dn_ready", cmd_if.cmd_ready, 1'b1);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        chk("held_set_taken", intensity, 4'd15);

        // 4: BREATHE peak 3 from 0, then OFF during the second ramp down
        push(0, 0);
        send(M_OFF, 4'd0, 4'd0);
        push(1, 0);  push(2, 4); push(3, 4);
        push(2, 12); push(1, 4); push(0, 4);
        push(1, 12); push(2, 4); push(3, 4);
        push(2, 12);
        send(M_BREATHE, 4'd3, 4'd0);
        chk("br_busy", busy, 1'b1);
        chk("br_ready", cmd_if.cmd_ready, 1'b1);
        drain(200);
        push(0, 1);
        send(M_OFF, 4'd0, 4'd0);
        chk("br_off_intensity", intensity, 4'd0);
        chk("br_off_busy", busy, 1'b0);
        repeat (12) cyc();

        // 5: FADE to the level already shown
        push(5, 0);
        send(M_SET, 4'd5, 4'd0);
        send(M_FADE, 4'd5, 4'd0);
        chk("fade_eq_done", done, 1'b1);
        chk("fade_eq_busy", busy, 1'b0);
        chk("fade_eq_ready", cmd_if.cmd_ready, 1'b1);
        cyc();
        chk("fade_eq_done_clear", done, 1'b0);
        chk("fade_eq_level", intensity, 4'd5);

        // 6: asynchronous reset in the middle of a FADE
        push(3, 0);
        send(M_SET, 4'd3, 4'd0);
        push(4, 0); push(5, 4); push(6, 4);
        send(M_FADE, 4'd9, 4'd0);
        drain(100);
        push(0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_intensity", intensity, 4'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", cmd_if.cmd_ready, 1'b1);
        chk("arst_done", done, 1'b0);
        cyc();
        cyc();
        chk("arst_done_held", done, 1'b0);
        rst_n = 1'b1;
        push(1, 0);
        send(M_FADE, 4'd1, 4'd0);
        chk("post_rst_busy", busy, 1'b1);
        wait_level(4'd1, 50);
        chk("post_rst_done", done, 1'b1);
        cyc();
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_ready", cmd_if.cmd_ready, 1'b1);

        chk("sb_leftover", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
